// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier sequencer.
package booth_pkg;

  // Default operand width in bits; the product is twice this wide.
  localparam int WIDTH_DEF = 8;

  // Sequencer states; the encodings are also shown on the LEDs.
  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_B  = 3'd1,
    LISTO     = 3'd2,
    CORRIENDO = 3'd3,
    MOSTRAR   = 3'd4,
    ERROR     = 3'd5
  } estado_sec_t;

endpackage

// File: rtl/contador_timeout.sv
// Run-cycle counter used to bound how long the sequencer waits for the
// Booth core. fin flags the last allowed cycle, TIMEOUT-1.
module contador_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic fin
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: a clear wins over counting.
  always_comb begin
    // NOTE: assign the default first so that no path leaves cnt_d unassigned and infers a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: every flop gets a known reset value; the sequencer relies on a clean count after rst.
    if (rst) begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fin = (cnt_q == TERMINAL);

endmodule

// File: rtl/secuenciador_booth.sv
// Operand entry and run sequencer for the Booth multiplier. It loads the
// two operands from the switch bank, launches the core with a one-cycle
// start, waits for done under a timeout and latches the product.
module secuenciador_booth
  import booth_pkg::*;
#(
  parameter int WIDTH   = booth_pkg::WIDTH_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sw,
  input  logic               btn_load,
  input  logic               btn_start,
  input  logic               btn_clear,
  input  logic               done,
  input  logic [2*WIDTH-1:0] producto,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               start,
  output logic [2*WIDTH-1:0] resultado,
  output logic               valido,
  output logic               error,
  output logic [2:0]         fase
);

  estado_sec_t        state_q,     state_d;
  logic [WIDTH-1:0]   op_a_q,      op_a_d;
  logic [WIDTH-1:0]   op_b_q,      op_b_d;
  logic               start_q,     start_d;
  logic [2*WIDTH-1:0] resultado_q, resultado_d;
  logic               valido_q,    valido_d;
  logic               error_q,     error_d;

  logic cnt_fin;
  logic cnt_en;

  // The counter restarts on the cycle that enters CORRIENDO (same
  // condition that raises start) and advances while running.
  assign cnt_en = (state_q == CORRIENDO);

  contador_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_contador_timeout (
    .clk (clk),
    .rst (rst),
    .clr (start_d),
    .en  (cnt_en),
    .fin (cnt_fin)
  );

  // Next-state and register updates; btn_clear outranks everything,
  // then done, then timeout, then btn_load, then btn_start.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    resultado_d = resultado_q;
    valido_d    = valido_q;
    error_d     = error_q;

    if (btn_clear) begin
      state_d     = ESPERA_A;
      op_a_d      = '0;
      op_b_d      = '0;
      resultado_d = '0;
      valido_d    = 1'b0;
      error_d     = 1'b0;
    end else begin
      unique case (state_q)
        ESPERA_A: begin
          if (btn_load) begin
            op_a_d  = sw;
            state_d = ESPERA_B;
          end
        end
        ESPERA_B: begin
          if (btn_load) begin
            op_b_d  = sw;
            state_d = LISTO;
          end
        end
        LISTO: begin
          if (btn_load) begin
            op_a_d  = sw;
            state_d = ESPERA_B;
          end else if (btn_start) begin
            state_d = CORRIENDO;
          end
        end
        CORRIENDO: begin
          // start_q marks the entry cycle, in which done is not trusted.
          if (!start_q && done) begin
            resultado_d = producto;
            valido_d    = 1'b1;
            state_d     = MOSTRAR;
          end else if (cnt_fin) begin
            error_d = 1'b1;
            state_d = ERROR;
          end
        end
        MOSTRAR: begin
          if (btn_load) begin
            op_a_d   = sw;
            valido_d = 1'b0;
            state_d  = ESPERA_B;
          end else if (btn_start) begin
            valido_d = 1'b0;
            state_d  = CORRIENDO;
          end
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = ESPERA_A;
        end
      endcase
    end

    // One-cycle launch pulse on every transition into CORRIENDO.
    start_d = (state_d == CORRIENDO) && (state_q != CORRIENDO);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ESPERA_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      start_q     <= 1'b0;
      resultado_q <= '0;
      valido_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      start_q     <= start_d;
      resultado_q <= resultado_d;
      valido_q    <= valido_d;
      error_q     <= error_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign start     = start_q;
  assign resultado = resultado_q;
  assign valido    = valido_q;
  assign error     = error_q;
  assign fase      = state_q;

endmodule

// File: tb/tb_secuenciador_booth.sv
// Bench for secuenciador_booth: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against
// a behavioural model of the sequencer.
module tb_secuenciador_booth;

  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   sw = '0;
  logic           btn_load = 1'b0;
  logic           btn_start = 1'b0;
  logic           btn_clear = 1'b0;
  logic           done = 1'b0;
  logic [2*W-1:0] producto = '0;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           start;
  logic [2*W-1:0] resultado;
  logic           valido;
  logic           error;
  logic [2:0]     fase;

  int n_checks = 0;
  int n_fail   = 0;

  secuenciador_booth #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .done      (done),
    .producto  (producto),
    .op_a      (op_a),
    .op_b      (op_b),
    .start     (start),
    .resultado (resultado),
    .valido    (valido),
    .error     (error),
    .fase      (fase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------
  // Behavioural model. m_fase holds the LED phase code; a run is timed
  // by the absolute cycle number at which its start pulse was shown.
  // ---------------------------------------------------------------
  int             m_fase = 0;
  logic [W-1:0]   m_a = '0;
  logic [W-1:0]   m_b = '0;
  logic [2*W-1:0] m_res = '0;
  logic           m_val = 1'b0;
  logic           m_err = 1'b0;
  logic           m_start = 1'b0;
  bit             m_ok = 1'b0;
  int             m_cyc = 0;
  int             m_t0 = 0;

  task automatic model_step();
    int nf;
    int run;
    nf = m_fase;
    if (rst || btn_clear) begin
      m_a = '0; m_b = '0; m_res = '0; m_val = 1'b0; m_err = 1'b0;
      nf = 0;
      if (rst) m_ok = 1'b1;
    end else begin
      case (m_fase)
        0: if (btn_load) begin m_a = sw; nf = 1; end
        1: if (btn_load) begin m_b = sw; nf = 2; end
        2: if (btn_load) begin m_a = sw; nf = 1; end
           else if (btn_start) nf = 3;
        3: begin
          run = m_cyc - m_t0;
          if (run != 0 && done) begin
            m_res = producto; m_val = 1'b1; nf = 4;
          end else if (run == TO - 1) begin
            m_err = 1'b1; nf = 5;
          end
        end
        4: if (btn_load) begin m_a = sw; m_val = 1'b0; nf = 1; end
           else if (btn_start) begin m_val = 1'b0; nf = 3; end
        default: ;
      endcase
    end
    m_start = (nf == 3) && (m_fase != 3);
    if (m_start) m_t0 = m_cyc + 1;
    m_fase = nf;
    m_cyc++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        check("op_a",      32'(op_a),      32'(m_a));
        check("op_b",      32'(op_b),      32'(m_b));
        check("start",     32'(start),     32'(m_start));
        check("resultado", 32'(resultado), 32'(m_res));
        check("valido",    32'(valido),    32'(m_val));
        check("error",     32'(error),     32'(m_err));
        check("fase",      32'(fase),      32'(m_fase));
      end
    end
  end

  // One cycle of stimulus; pulses last exactly one cycle.
  task automatic tick(input logic rs, input logic ld, input logic st, input logic cl,
                      input logic dn, input logic [W-1:0] s, input logic [2*W-1:0] p);
    rst = rs; btn_load = ld; btn_start = st; btn_clear = cl; done = dn;
    sw = s; producto = p;
    @(posedge clk);
    #1;
    rst = 1'b0; btn_load = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int core_rem;
    logic ld, st, cl, rs, dn;

    // Reset.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    check("rst_fase",  32'(fase),      32'd0);
    check("rst_res",   32'(resultado), 32'd0);
    check("rst_start", 32'(start),     32'd0);

    // Load and run: 5 x -3 with done 9 cycles after start.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 16'h0000);
    check("load_a", 32'(op_a), 32'h05);
    check("load_a_fase", 32'(fase), 32'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD, 16'h0000);
    check("load_b", 32'(op_b), 32'hFD);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    check("start_pulse", 32'(start), 32'd1);
    idle(1);
    check("start_one_cycle", 32'(start), 32'd0);
    idle(8);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'hFFF1);
    check("run_res",    32'(resultado), 32'hFFF1);
    check("run_valido", 32'(valido),    32'd1);
    check("run_fase",   32'(fase),      32'd4);
    check("model_pin_res", 32'(m_res),  32'hFFF1);

    // Rerun from MOSTRAR; a done in the entry cycle must be ignored.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    check("rerun_start",  32'(start),  32'd1);
    check("rerun_valido", 32'(valido), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'hDEAD);
    check("entry_done_ignored", 32'(fase), 32'd3);
    idle(3);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'hFFF1);
    check("rerun_res",    32'(resultado), 32'hFFF1);
    check("rerun_valid1", 32'(valido),    32'd1);

    // Done in the terminal-count cycle (start cycle + 15).
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(15);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h1234);
    check("term_valido", 32'(valido),    32'd1);
    check("term_error",  32'(error),     32'd0);
    check("term_res",    32'(resultado), 32'h1234);

    // Timeout with done held low.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(15);
    check("to_not_yet", 32'(fase), 32'd3);
    idle(1);
    check("to_fase",  32'(fase),  32'd5);
    check("to_error", 32'(error), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 16'h0000);
    check("err_hold_fase", 32'(fase),  32'd5);
    check("err_hold_a",    32'(op_a),  32'h05);
    check("err_no_start",  32'(start), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
    check("clr_fase",  32'(fase),  32'd0);
    check("clr_out",   32'({op_a, op_b, resultado, valido, error}), 32'd0);

    // Simultaneous pulses.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 16'h0000);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 16'h0000);
    check("clr_load_fase", 32'(fase), 32'd0);
    check("clr_load_a",    32'(op_a), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 16'h0000);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 16'h0000);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 16'h0000);
    check("load_start_fase",  32'(fase),  32'd1);
    check("load_start_a",     32'(op_a),  32'h55);
    check("load_start_nostart", 32'(start), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 16'h0000);

    // Reset three cycles after start, then a late done from the core.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(3);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(2);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'hBEEF);
    check("rstrun_fase",   32'(fase),      32'd0);
    check("rstrun_res",    32'(resultado), 32'd0);
    check("rstrun_valido", 32'(valido),    32'd0);

    // Randomized traffic with an emulated core answering each start.
    core_rem = 0;
    for (int i = 0; i < 3000; i++) begin
      dn = 1'b0;
      if (start) begin
        core_rem = int'($urandom_range(1, 20));
      end else if (core_rem > 0) begin
        core_rem--;
        if (core_rem == 0) dn = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) dn = 1'b1;
      ld = ($urandom_range(0, 4) == 0);
      st = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 199) == 0);
      tick(rs, ld, st, cl, dn, 8'($urandom), 16'($urandom));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/secuenciador_booth.md
# secuenciador_booth

Operand-entry and run sequencer for the Booth multiplier. Consumes single-cycle button pulses from the input subsystem's pulse converters plus the switch bank. Loads multiplicand and multiplier into holding registers, issues a one-cycle `start` to the Booth core and waits for its `done` under a timeout. Latches the product for the display subsystem.

## Interface
- `WIDTH`, 8: operand width in bits; product is 2*WIDTH.
- `TIMEOUT`, 64: maximum RUN cycles allowed without `done`; must satisfy 2 ≤ TIMEOUT ≤ 2^16.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sw`  in  WIDTH  switch bank, sampled on an accepted `btn_load`.
- `btn_load`  in  1  one-cycle pulse: capture `sw` as next operand.
- `btn_start`  in  1  one-cycle pulse: launch multiplication.
- `btn_clear`  in  1  one-cycle pulse: abort and return to idle.
- `done`  in  1  Booth core completion pulse; `producto` valid in the same cycle.
- `producto`  in  2*WIDTH  Booth core result.
- `op_a`  out  WIDTH  multiplicand register to core.
- `op_b`  out  WIDTH  multiplier register to core.
- `start`  out  1  one-cycle launch pulse to core.
- `resultado`  out  2*WIDTH  latched product.
- `valido`  out  1  `resultado` holds a product from the current operands.
- `error`  out  1  timeout occurred.
- `fase`  out  3  current state encoding, for LEDs.

## Operation
- States and `fase` codes: ESPERA_A=0, ESPERA_B=1, LISTO=2, CORRIENDO=3, MOSTRAR=4, ERROR=5.
- ESPERA_A: on `btn_load`, set `op_a`←`sw` and go to ESPERA_B.
- ESPERA_B: on `btn_load`, set `op_b`←`sw` and go to LISTO.
- LISTO:
  - `btn_start` → CORRIENDO.
  - `btn_load` → capture `op_a`←`sw` and go to ESPERA_B (re-entry of both operands).
- CORRIENDO:
  - On entry, `start`=1 for exactly the entry cycle; the timeout counter loads 0 and increments each RUN cycle.
  - `done` is ignored in the entry cycle and sampled in every later cycle.
  - On `done`: `resultado`←`producto`, `valido`←1, go to MOSTRAR.
  - If the counter reaches TIMEOUT-1 without `done`: `error`←1, go to ERROR.
  - `btn_load` and `btn_start` are ignored.
- MOSTRAR:
  - `btn_start` → CORRIENDO with the same operands; `valido`←0 on exit.
  - `btn_load` → `op_a`←`sw`, `valido`←0, go to ESPERA_B.
- ERROR: only `btn_clear` or `rst` exits.
- `btn_clear`, in any state: go to ESPERA_A and set `op_a`, `op_b`, `resultado`, `valido`, `error` to 0.
- Priority within a cycle: `rst` > `btn_clear` > `done` > timeout > `btn_load` > `btn_start`.
- Operands are treated as two's-complement. The block does no arithmetic; `producto` is stored unmodified.
- Switch changes outside an accepted `btn_load` have no effect.

## Timing
- Reset values: state ESPERA_A; `op_a`=0, `op_b`=0, `start`=0, `resultado`=0, `valido`=0, `error`=0, `fase`=0.
- All outputs are registered.
- `btn_start` in cycle N → `start`=1 in cycle N+1 only.
- `done` in cycle M → `resultado`/`valido` updated and `fase`=4 in cycle M+1.
- Timeout: with no `done`, `error`=1 and `fase`=5 exactly TIMEOUT cycles after the `start` cycle.
- `done` in the same cycle as the terminal count → the product is accepted and no error is raised.
- `btn_load` in cycle N → the new register value is visible in N+1.
- `rst` or `btn_clear` mid-run: `start` is not reasserted. A later `done` from the core is ignored, because the block is no longer in CORRIENDO.

## Structure
- Package `booth_pkg`: state enum `estado_sec_t` with the `fase` codes above, and the default `WIDTH` constant.
- Sub-module `contador_timeout`:
  - Ports: `clk`, `rst`, `clr`, `en`, `fin`.
  - Width $clog2(TIMEOUT).
  - `fin` asserts combinationally at TIMEOUT-1.
- The FSM and the operand/result registers stay in the top module.

## Test plan
- Load and run:
  - Stimulus: `sw`=0x05 + `btn_load`, then `sw`=0xFD + `btn_load`, then `btn_start`; core answers `done` 9 cycles after `start` with `producto`=0xFFF1.
  - Required: `op_a`=0x05, `op_b`=0xFD, one-cycle `start`, `resultado`=0xFFF1, `valido`=1, `fase`=4.
- Timeout:
  - Stimulus: TIMEOUT=16, `done` held low.
  - Required: `error`=1 and `fase`=5 exactly 16 cycles after `start`. `btn_start`/`btn_load` in ERROR → no change. `btn_clear` → `fase`=0 and all outputs 0.
- Done at terminal count:
  - Stimulus: `done` in the cycle the counter is TIMEOUT-1.
  - Required: `valido`=1, `error`=0.
- Rerun from MOSTRAR:
  - Stimulus: `btn_start` with unchanged operands.
  - Required: new `start` pulse, `valido`=0 during the run, result re-latched.
- Simultaneous pulses:
  - `btn_clear`+`btn_load` in ESPERA_B → ESPERA_A, `op_a`=0.
  - `btn_load`+`btn_start` in LISTO → ESPERA_B, no `start`.
- Reset mid-run:
  - Stimulus: `rst` 3 cycles after `start`; core later pulses `done`.
  - Required: state stays ESPERA_A, `resultado`=0, `valido`=0.
